mmio_initiator: RTL and testbench

- Initiator (hub side) of the MCU's memory-mapped IO bus. It accepts single-beat load/store requests from the CPU memory stage over a valid/ready handshake.
- Drives the MMIO request fields (en, we, word address, byte enables, write data) to the board-peripheral responder, honours the responder's hold, captures registered read data, and returns one response per request.
- Adds a hold timeout and misalignment check, so a hung or bad access returns an error instead of stalling the pipeline forever.

---
 rtl/mmio_bridge_pkg.sv | 14 +
 rtl/mmio_initiator_if.sv | 39 +++
 rtl/mmio_hold_timer.sv | 38 +++
 rtl/mmio_initiator.sv | 147 ++++++++++++++
 tb/tb_mmio_initiator.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared types and constants for the MMIO initiator and its timer.
package mmio_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait,
    StResp
  } state_e;

  localparam logic [31:0] ErrRdataDefault = 32'hDEADBEEF;
  localparam int unsigned MmioAddrW       = 30;

endpackage

// File: rtl/mmio_initiator_if.sv
// CPU request/response channel plus MMIO bus signals around the initiator.
interface mmio_initiator_if;
  import mmio_bridge_pkg::*;

  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic                 cpu_req_we;
  logic [31:0]          cpu_req_addr;
  logic [3:0]           cpu_req_be;
  logic [31:0]          cpu_req_data;
  logic                 cpu_rsp_valid;
  logic                 cpu_rsp_ready;
  logic [31:0]          cpu_rsp_data;
  logic                 cpu_rsp_err;
  logic                 mmio_en;
  logic                 mmio_we;
  logic [MmioAddrW-1:0] mmio_waddr;
  logic [3:0]           mmio_be;
  logic [31:0]          mmio_din;
  logic [31:0]          mmio_dout;
  logic                 mmio_hold;

  // Initiator view.
  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_be, cpu_req_data,
    input  cpu_rsp_ready, mmio_dout, mmio_hold,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_err,
    output mmio_en, mmio_we, mmio_waddr, mmio_be, mmio_din
  );

  // CPU plus responder view.
  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_be, cpu_req_data,
    output cpu_rsp_ready, mmio_dout, mmio_hold,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_err,
    input  mmio_en, mmio_we, mmio_waddr, mmio_be, mmio_din
  );

endinterface

// File: rtl/mmio_hold_timer.sv
// Counts consecutive hold cycles of an issued access; flags the last allowed one.
module mmio_hold_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This hold edge would push the count to TIMEOUT_CYCLES: abort now.
  assign expired = enable && (cnt_q == LastCnt);

endmodule

// File: rtl/mmio_initiator.sv
// MMIO bus initiator: single-beat CPU loads/stores with hold timeout and alignment check.
module mmio_initiator
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ErrRdataDefault
) (
  input logic              clk,
  input logic              rst_n,
  mmio_initiator_if.master bus
);

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 en_q, en_d;
  logic                 we_q, we_d;
  logic [MmioAddrW-1:0] waddr_q, waddr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          din_q, din_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 timer_clear;
  logic                 timer_expired;

  mmio_hold_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (state_q == StIssue && bus.mmio_hold),
    .expired(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    en_d        = en_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    be_d        = be_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (ready_q && bus.cpu_req_valid) begin
          ready_d = 1'b0;
          if (bus.cpu_req_addr[1:0] != 2'b00) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = bus.cpu_req_we ? 32'h0 : ERR_RDATA;
          end else begin
            state_d     = StIssue;
            en_d        = 1'b1;
            we_d        = bus.cpu_req_we;
            waddr_d     = bus.cpu_req_addr[31:2];
            be_d        = bus.cpu_req_be;
            din_d       = bus.cpu_req_data;
            timer_clear = 1'b1;
          end
        end
      end
      StIssue: begin
        // we_q still holds the request direction while EN is high.
        if (!bus.mmio_hold) begin
          en_d = 1'b0;
          we_d = 1'b0;
          if (we_q) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = 32'h0;
          end else begin
            state_d = StRdWait;
          end
        end else if (timer_expired) begin
          en_d        = 1'b0;
          we_d        = 1'b0;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = we_q ? 32'h0 : ERR_RDATA;
        end
      end
      StRdWait: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = bus.mmio_dout;
      end
      StResp: begin
        if (bus.cpu_rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      be_q        <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      be_q        <= be_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cpu_req_ready = ready_q;
  assign bus.cpu_rsp_valid = rsp_valid_q;
  assign bus.cpu_rsp_data  = rsp_data_q;
  assign bus.cpu_rsp_err   = rsp_err_q;
  assign bus.mmio_en       = en_q;
  assign bus.mmio_we       = we_q;
  assign bus.mmio_waddr    = waddr_q;
  assign bus.mmio_be       = be_q;
  assign bus.mmio_din      = din_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Randomized bench for mmio_initiator against a per-transaction timing/data model.
module tb_mmio_initiator;

  localparam int unsigned Timeout = 8;
  localparam logic [31:0] ErrData = 32'hDEADBEEF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mmio_initiator_if bus_if ();

  mmio_initiator #(
    .TIMEOUT_CYCLES(Timeout),
    .ERR_RDATA     (ErrData)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Runs one request; timing is derived from hold count, direction, alignment and stall.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int nhold, input logic [31:0] rdata,
                         input int stall);
    bit          mis      = (addr[1:0] != 2'b00);
    bit          tmo      = !mis && (nhold >= int'(Timeout));
    int          en_cyc   = mis ? 0 : (tmo ? int'(Timeout) : nhold + 1);
    int          rsp_cyc  = mis ? 1 : ((we || tmo) ? en_cyc + 1 : en_cyc + 2);
    int          done_cyc = rsp_cyc + stall;
    bit          exp_err  = mis || tmo;
    logic [31:0] exp_data = we ? 32'h0 : (exp_err ? ErrData : rdata);
    bit          exp_en;
    bit          exp_rv;

    @(negedge clk);
    check("idle_ready", {31'h0, bus_if.cpu_req_ready}, 32'h1);
    bus_if.cpu_req_valid = 1'b1;
    bus_if.cpu_req_we    = we;
    bus_if.cpu_req_addr  = addr;
    bus_if.cpu_req_be    = be;
    bus_if.cpu_req_data  = wdata;
    bus_if.mmio_hold     = 1'($urandom_range(0, 1));
    bus_if.cpu_rsp_ready = 1'($urandom_range(0, 1));

    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus_if.cpu_req_valid = 1'b0;
        bus_if.cpu_req_we    = 1'($urandom_range(0, 1));
        bus_if.cpu_req_addr  = $urandom;
        bus_if.cpu_req_be    = 4'($urandom);
        bus_if.cpu_req_data  = $urandom;
      end
      exp_en = (c <= en_cyc);
      exp_rv = (c >= rsp_cyc) && (c <= done_cyc);
      check("mmio_en", {31'h0, bus_if.mmio_en}, {31'h0, exp_en});
      check("mmio_we", {31'h0, bus_if.mmio_we}, {31'h0, exp_en & we});
      if (exp_en) begin
        check("mmio_waddr", {2'b00, bus_if.mmio_waddr}, {2'b00, addr[31:2]});
        check("mmio_be", {28'h0, bus_if.mmio_be}, {28'h0, be});
        check("mmio_din", bus_if.mmio_din, wdata);
      end
      check("rsp_valid", {31'h0, bus_if.cpu_rsp_valid}, {31'h0, exp_rv});
      if (exp_rv) begin
        check("rsp_data", bus_if.cpu_rsp_data, exp_data);
        check("rsp_err", {31'h0, bus_if.cpu_rsp_err}, {31'h0, exp_err});
      end
      check("req_ready", {31'h0, bus_if.cpu_req_ready}, {31'h0, c > done_cyc});

      bus_if.mmio_hold = (c <= en_cyc) ? (c <= nhold) : 1'($urandom_range(0, 1));
      bus_if.mmio_dout = (!we && !exp_err && c == en_cyc + 1) ? rdata : $urandom;
      bus_if.cpu_rsp_ready = exp_rv ? (c == done_cyc) : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.cpu_req_valid = 1'b0;
    bus_if.cpu_req_we    = 1'b0;
    bus_if.cpu_req_addr  = 32'h0;
    bus_if.cpu_req_be    = 4'h0;
    bus_if.cpu_req_data  = 32'h0;
    bus_if.cpu_rsp_ready = 1'b0;
    bus_if.mmio_dout     = 32'h0;
    bus_if.mmio_hold     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_en", {31'h0, bus_if.mmio_en}, 32'h0);
    check("rst_we", {31'h0, bus_if.mmio_we}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus_if.cpu_rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, bus_if.cpu_rsp_err}, 32'h0);
    check("rst_rsp_data", bus_if.cpu_rsp_data, 32'h0);
    rst_n = 1'b1;

    run_txn(1'b1, 32'h1108_0000, 4'b0011, 32'h0000_A5A5, 0, 32'h0, 0);
    run_txn(1'b0, 32'h1100_0000, 4'b1111, 32'h0, 0, 32'h0000_1234, 1);
    run_txn(1'b0, 32'h1140_0000, 4'b1111, 32'h0, 3, 32'h0000_0042, 0);
    run_txn(1'b0, 32'h1120_0010, 4'b1111, 32'h0, 100, 32'h5555_5555, 0);
    run_txn(1'b1, 32'h1120_0014, 4'b1100, 32'hCAFE_0000, 8, 32'h0, 2);
    run_txn(1'b0, 32'h1120_0018, 4'b1111, 32'h0, 7, 32'h7777_0007, 0);
    run_txn(1'b1, 32'h1108_0002, 4'b1111, 32'h1234_5678, 0, 32'h0, 5);
    run_txn(1'b0, 32'h1108_0001, 4'b1111, 32'h0, 0, 32'h0, 1);

    // Reset in the middle of a held load: no response may survive.
    @(negedge clk);
    bus_if.cpu_req_valid = 1'b1;
    bus_if.cpu_req_we    = 1'b0;
    bus_if.cpu_req_addr  = 32'h1100_0000;
    bus_if.mmio_hold     = 1'b1;
    @(negedge clk);
    bus_if.cpu_req_valid = 1'b0;
    check("pre_rst_en", {31'h0, bus_if.mmio_en}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_en", {31'h0, bus_if.mmio_en}, 32'h0);
    check("async_rst_rsp_valid", {31'h0, bus_if.cpu_rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.mmio_hold = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'h0, bus_if.cpu_req_ready}, 32'h1);
    check("post_rst_rsp_valid", {31'h0, bus_if.cpu_rsp_valid}, 32'h0);
    run_txn(1'b1, 32'h110C_0000, 4'b1111, 32'h0BAD_F00D, 0, 32'h0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      int          nh;
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      nh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12))
                                       : int'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, nh, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
